// File: rtl/mips_multicycle_controller_if.sv
// Datapath control bus of the multi-cycle MIPS controller.
//   Datapath to controller: opcode (IR[31:26]), Zero (ALU flag), MemReady (memory done).
//   Controller to datapath: memory request/select, IR/PC/register-file write enables,
//   mux selects, ALU operation and PC source.
//   master: the controller side; slave: the datapath side.
interface mips_multicycle_controller_if;
  logic [5:0] opcode;
  logic       Zero;
  logic       MemReady;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOperation;
  logic [1:0] PCSrc;
  logic       PCEn;

  modport master (
    input  opcode, Zero, MemReady,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOperation, PCSrc, PCEn
  );

  modport slave (
    output opcode, Zero, MemReady,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOperation, PCSrc, PCEn
  );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Control FSM for a multi-cycle MIPS datapath sharing one memory for code and data.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; forces every output to 0 while high
//   bus          datapath control bus (master side), see mips_multicycle_controller_if
//   Illegal      sticky flag, set when an unknown opcode sends the FSM to HALT
//   State        current state code, debug only
//   RetiredCount instructions completed since reset, wraps at 2^CNT_W
//
// state  | meaning
// 0  FETCH  | read instruction at PC, PC <= PC+4 when memory is ready
// 1  DECODE | sample opcode, precompute branch target into ALUOut
// 2  MEMADR | base + offset for lw/sw
// 3  MEMRD  | data read, held until MemReady
// 4  MEMWB  | MDR -> rt
// 5  MEMWR  | data write, held until MemReady
// 6  EXEC   | R-type ALU operation
// 7  ALUWB  | ALUOut -> rd
// 8  BRANCH | compare for beq, PC <= target if Zero
// 9  ADDIEX | A + signext imm
// 10 ADDIWB | ALUOut -> rt
// 11 JUMP   | PC <= jump target
// 12 HALT   | illegal opcode, wait for reset
module mips_multicycle_controller #(
  parameter int         CNT_W    = 32,
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic                        clk,
  input  logic                        rst,
  mips_multicycle_controller_if.master bus,
  output logic                        Illegal,
  output logic [3:0]                  State,
  output logic [CNT_W-1:0]            RetiredCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  state_t           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;
  logic             retire;

  logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en;
  logic [1:0] alu_src_b, alu_op, pc_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_HALT) illegal_q <= 1'b1;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC load on the same edge the memory delivers the word
        ir_write  = bus.MemReady;
        pc_en     = bus.MemReady;
        if (bus.MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_d = S_MEMADR;
        else if (bus.opcode == OP_RTYPE)                state_d = S_EXEC;
        else if (bus.opcode == OP_BEQ)                  state_d = S_BRANCH;
        else if (bus.opcode == OP_ADDI)                 state_d = S_ADDIEX;
        else if (bus.opcode == OP_J)                    state_d = S_JUMP;
        else                                            state_d = S_HALT;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.MemReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = bus.Zero;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Outputs are held at zero for as long as reset is high, not just after the edge
  assign bus.IorD         = ~rst & iord;
  assign bus.MemRead      = ~rst & mem_read;
  assign bus.MemWrite     = ~rst & mem_write;
  assign bus.IRWrite      = ~rst & ir_write;
  assign bus.RegDst       = ~rst & reg_dst;
  assign bus.MemToReg     = ~rst & mem_to_reg;
  assign bus.RegWrite     = ~rst & reg_write;
  assign bus.ALUSrcA      = ~rst & alu_src_a;
  assign bus.ALUSrcB      = rst ? 2'b00 : alu_src_b;
  assign bus.ALUOperation = rst ? 2'b00 : alu_op;
  assign bus.PCSrc        = rst ? 2'b00 : pc_src;
  assign bus.PCEn         = ~rst & pc_en;
  assign Illegal          = ~rst & illegal_q;
  assign State            = rst ? 4'd0 : state_q;
  assign RetiredCount     = rst ? '0 : count_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
module tb_mips_multicycle_controller;
  localparam int CW = 4;  // small counter so the wrap is reached

  localparam logic [5:0] RTYPE = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, ADDI = 6'h08, J = 6'h02;

  logic          clk = 1'b0;
  logic          rst;
  logic          Illegal;
  logic [3:0]    State;
  logic [CW-1:0] RetiredCount;

  mips_multicycle_controller_if bus();

  mips_multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .Illegal(Illegal), .State(State), .RetiredCount(RetiredCount)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int m_count = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected controls for one cycle, straight from the per-step description of the machine.
  // Order: IorD MemRead MemWrite IRWrite RegDst MemToReg RegWrite ALUSrcA ALUSrcB ALUOp PCSrc PCEn
  function automatic logic [14:0] ctrl_of(input int s, input bit mr, input bit z);
    logic iord = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, asa = 0, pce = 0;
    logic [1:0] asb = 0, aop = 0, pcs = 0;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pce = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pce = z; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pce = 1; end
      default: ;
    endcase
    return {iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, pcs, pce};
  endfunction

  function automatic logic [14:0] obs_ctrl();
    return {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemToReg,
            bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOperation, bus.PCSrc, bus.PCEn};
  endfunction

  // One clock with rst high: everything must read zero.
  task automatic rst_step();
    @(negedge clk);
    rst = 1'b1;
    bus.MemReady = 1'($urandom);
    bus.Zero     = 1'($urandom);
    bus.opcode   = 6'($urandom);
    #1;
    check("rst_state", State, 0);
    check("rst_ctrl", obs_ctrl(), 0);
    check("rst_illegal", Illegal, 0);
    check("rst_count", RetiredCount, 0);
    m_count = 0;
  endtask

  task automatic step(input int s, input bit mr, input bit z, input logic [5:0] op, input bit ill);
    @(negedge clk);
    rst = 1'b0;
    bus.MemReady = mr;
    bus.Zero     = z;
    bus.opcode   = op;
    #1;
    check("state", State, s);
    check("ctrl", obs_ctrl(), ctrl_of(s, mr, z));
    check("illegal", Illegal, ill);
    check("count", RetiredCount, m_count);
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // Walk one instruction: fw wait cycles in FETCH, mw wait cycles on the data access.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit z);
    for (int i = 0; i <= fw; i++) step(0, i == fw, rb(), 6'($urandom), 0);
    step(1, rb(), rb(), op, 0);
    case (op)
      RTYPE: begin step(6, rb(), rb(), op, 0); step(7, rb(), rb(), op, 0); end
      LW: begin
        step(2, rb(), rb(), op, 0);
        for (int i = 0; i <= mw; i++) step(3, i == mw, rb(), op, 0);
        step(4, rb(), rb(), op, 0);
      end
      SW: begin
        step(2, rb(), rb(), op, 0);
        for (int i = 0; i <= mw; i++) step(5, i == mw, rb(), op, 0);
      end
      BEQ:  step(8, rb(), z, op, 0);
      ADDI: begin step(9, rb(), rb(), op, 0); step(10, rb(), rb(), op, 0); end
      J:    step(11, rb(), rb(), op, 0);
      default: begin
        for (int i = 0; i < 10; i++) step(12, rb(), rb(), 6'($urandom), 1);
        return;
      end
    endcase
    m_count = (m_count + 1) % (1 << CW);
  endtask

  function automatic logic [5:0] rand_legal();
    logic [5:0] ops [6];
    ops = '{RTYPE, LW, SW, BEQ, ADDI, J};
    return ops[$urandom_range(0, 5)];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] bad;
    rst = 1'b1;
    bus.MemReady = 1'b1;
    bus.Zero = 1'b0;
    bus.opcode = 6'h00;

    rst_step();
    rst_step();

    run_instr(RTYPE, 0, 0, 0);
    run_instr(LW, 0, 3, 0);
    run_instr(BEQ, 0, 0, 1);
    run_instr(BEQ, 0, 0, 0);
    run_instr(SW, 0, 0, 0);
    run_instr(ADDI, 2, 0, 0);
    run_instr(J, 0, 0, 0);
    run_instr(SW, 1, 2, 0);

    for (int k = 0; k < 40; k++)
      run_instr(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 3), rb());

    run_instr(6'h3F, 0, 0, 0);
    rst_step();
    run_instr(ADDI, 0, 0, 0);

    do bad = 6'($urandom);
    while (bad inside {RTYPE, LW, SW, BEQ, ADDI, J});
    run_instr(bad, 1, 0, 0);
    rst_step();

    // Reset in the middle of a stalled store aborts it.
    run_instr(RTYPE, 0, 0, 0);
    step(0, 1, rb(), 6'($urandom), 0);
    step(1, rb(), rb(), SW, 0);
    step(2, rb(), rb(), SW, 0);
    step(5, 0, rb(), SW, 0);
    step(5, 0, rb(), SW, 0);
    rst_step();
    step(0, 0, rb(), 6'($urandom), 0);
    step(0, 1, rb(), 6'($urandom), 0);
    step(1, rb(), rb(), J, 0);
    step(11, rb(), rb(), J, 0);
    m_count = (m_count + 1) % (1 << CW);
    step(0, 1, rb(), 6'($urandom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
